writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_pkg.sv | 30 +++
 rtl/writeback_unit_fifo.sv | 62 ++++++
 rtl/writeback_unit.sv | 161 ++++++++++++++++
 tb/tb_writeback_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared processor types used by the writeback stage.
// Provides XLEN, register-number width, the load FIFO entry and the commit select.
package writeback_unit_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int NREGS = 1 << REG_W;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]  xword_t;

    typedef struct packed {
        reg_idx_t rd;
        xword_t   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_FIFO = 2'd2
    } wb_sel_e;

    function automatic logic [NREGS-1:0] reg_onehot(input reg_idx_t idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/writeback_unit_fifo.sv
// Load-result FIFO: DEPTH entries of {rd, data}, power-of-two depth.
// Ports: clk, rst (sync, high), push/din, pop/dout, full, empty, count.
import writeback_unit_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  wb_entry_t      din,
    input  logic           pop,
    output wb_entry_t      dout,
    output logic           full,
    output logic           empty,
    output logic [CW-1:0]  count
);

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Guard locally so a careless caller cannot corrupt the pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results against buffered load results,
// with a starvation guard, a pending-load scoreboard and a registered RF write port.
// Ports: alu_* (valid/ready/rd/data), mem_* (valid/ready/rd/data),
//        issue_mark/issue_rd, pending[31:0], rf_we/rf_dst/rf_wdata.
import writeback_unit_pkg::*;

module writeback_unit #(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [REG_W-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             issue_mark,
    input  logic [REG_W-1:0] issue_rd,
    output logic [NREGS-1:0] pending,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_dst,
    output logic [XLEN-1:0]  rf_wdata
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1) + 1;

    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic [SW-1:0]    starve_cnt;
    logic             starve_grant;
    wb_sel_e          sel;

    reg_idx_t         commit_rd;
    xword_t           commit_data;
    logic             commit;

    logic [NREGS-1:0] pending_nxt;

    assign push_entry = '{rd: mem_rd, data: mem_data};

    // No acceptance while in reset, and none when full (no pass-through).
    assign mem_ready = !rst && !fifo_full;
    assign fifo_push = mem_valid && mem_ready;

    wb_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign starve_grant = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
    assign alu_ready    = rst || !starve_grant;

    // Priority: starved head, then ALU, then head when the ALU is idle.
    always_comb begin
        sel = SEL_NONE;
        if (rst) begin
            sel = SEL_NONE;
        end else if (starve_grant) begin
            sel = SEL_FIFO;
        end else if (alu_valid) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel = SEL_FIFO;
        end
    end

    assign fifo_pop = (sel == SEL_FIFO);

    always_comb begin
        commit      = 1'b0;
        commit_rd   = '0;
        commit_data = '0;
        unique case (sel)
            SEL_ALU: begin
                commit      = 1'b1;
                commit_rd   = alu_rd;
                commit_data = alu_data;
            end
            SEL_FIFO: begin
                commit      = 1'b1;
                commit_rd   = head.rd;
                commit_data = head.data;
            end
            default: begin
                commit = 1'b0;
            end
        endcase
    end

    // Counts cycles a waiting head loses to the ALU.
    always_ff @(posedge clk) begin
        if (rst || fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (sel == SEL_ALU) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // A same-cycle set overrides the clear; x0 never pends.
    always_comb begin
        pending_nxt = pending;
        if (fifo_pop) begin
            pending_nxt = pending_nxt & ~reg_onehot(head.rd);
        end
        if (issue_mark && (issue_rd != '0)) begin
            pending_nxt = pending_nxt | reg_onehot(issue_rd);
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_dst   <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= commit && (commit_rd != '0);
            if (commit && (commit_rd != '0)) begin
                rf_dst   <= commit_rd;
                rf_wdata <= commit_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_full == (fifo_count == CW'(QDEPTH)))
            else $error("fifo count/full disagree");
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, loads, starvation,
// FIFO full, x0 handling, set-wins scoreboard and mid-run reset.
import writeback_unit_pkg::*;

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_mark;
    logic [4:0]  issue_rd;
    logic [31:0] pending;
    logic        rf_we;
    logic [4:0]  rf_dst;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_unit #(
        .QDEPTH       (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .issue_mark (issue_mark),
        .issue_rd   (issue_rd),
        .pending    (pending),
        .rf_we      (rf_we),
        .rf_dst     (rf_dst),
        .rf_wdata   (rf_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        mem_valid  = 1'b0;
        mem_rd     = '0;
        mem_data   = '0;
        issue_mark = 1'b0;
        issue_rd   = '0;

        // reset state
        tick();
        tick();
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_dst", 32'(rf_dst), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_pending", pending, 32'd0);
        rst = 1'b0;
        settle();
        check("idle_mem_ready", 32'(mem_ready), 32'd1);

        // ALU-only commit
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'h1234;
        tick();
        alu_valid = 1'b0;
        check("alu_we", 32'(rf_we), 32'd1);
        check("alu_dst", 32'(rf_dst), 32'd5);
        check("alu_data", rf_wdata, 32'h1234);
        tick();
        check("alu_we_drop", 32'(rf_we), 32'd0);
        check("alu_dst_hold", 32'(rf_dst), 32'd5);
        check("alu_data_hold", rf_wdata, 32'h1234);

        // load commit with scoreboard
        issue_mark = 1'b1;
        issue_rd   = 5'd7;
        tick();
        issue_mark = 1'b0;
        check("ld_pend_set", pending, 32'h0000_0080);
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 32'hAA;
        tick();
        mem_valid = 1'b0;
        check("ld_pend_hold", pending, 32'h0000_0080);
        check("ld_no_we_yet", 32'(rf_we), 32'd0);
        tick();
        check("ld_we", 32'(rf_we), 32'd1);
        check("ld_dst", 32'(rf_dst), 32'd7);
        check("ld_data", rf_wdata, 32'hAA);
        check("ld_pend_clr", pending, 32'd0);
        tick();

        // starvation: head loses three times, then wins
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h10;
        mem_valid = 1'b1;
        mem_rd    = 5'd9;
        mem_data  = 32'h99;
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stv_alu_rdy%0d", i), 32'(alu_ready), 32'd1);
            tick();
            check($sformatf("stv_alu_dst%0d", i), 32'(rf_dst), 32'd1);
        end
        check("stv_grant", 32'(alu_ready), 32'd0);
        tick();
        check("stv_we", 32'(rf_we), 32'd1);
        check("stv_dst", 32'(rf_dst), 32'd9);
        check("stv_data", rf_wdata, 32'h99);
        check("stv_rdy_back", 32'(alu_ready), 32'd1);
        alu_valid = 1'b0;
        tick();

        // FIFO full with ALU busy, held 5th push, order kept
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        alu_data  = 32'h20;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            mem_rd    = 5'(10 + i);
            mem_data  = 32'hA0 + 32'(i);
            settle();
            check($sformatf("full_rdy%0d", i), 32'(mem_ready), 32'd1);
            tick();
        end
        mem_rd   = 5'd14;
        mem_data = 32'hA4;
        settle();
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        check("full_grant", 32'(alu_ready), 32'd0);
        tick();
        check("full_pop_dst", 32'(rf_dst), 32'd10);
        check("full_pop_data", rf_wdata, 32'hA0);
        check("full_reopen", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        check("full_alu_dst", 32'(rf_dst), 32'd2);
        for (int j = 1; j < 5; j++) begin
            tick();
            check($sformatf("order_dst%0d", j), 32'(rf_dst), 32'(10 + j));
            check($sformatf("order_dat%0d", j), rf_wdata, 32'hA0 + 32'(j));
        end
        tick();
        check("drain_we", 32'(rf_we), 32'd0);

        // rd = 0 handling
        issue_mark = 1'b1;
        issue_rd   = 5'd0;
        tick();
        issue_mark = 1'b0;
        check("x0_pend", pending, 32'd0);
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 32'h55;
        tick();
        mem_valid = 1'b0;
        tick();
        check("x0_we", 32'(rf_we), 32'd0);
        check("x0_dst_hold", 32'(rf_dst), 32'd14);
        check("x0_data_hold", rf_wdata, 32'hA4);
        tick();
        check("x0_consumed", 32'(rf_we), 32'd0);

        // set wins over clear on the same rd
        issue_mark = 1'b1;
        issue_rd   = 5'd8;
        tick();
        issue_mark = 1'b0;
        mem_valid  = 1'b1;
        mem_rd     = 5'd8;
        mem_data   = 32'h88;
        tick();
        mem_valid  = 1'b0;
        issue_mark = 1'b1;
        tick();
        issue_mark = 1'b0;
        check("sw_dst", 32'(rf_dst), 32'd8);
        check("sw_pend", pending, 32'h0000_0100);
        mem_valid = 1'b1;
        mem_data  = 32'h89;
        tick();
        mem_valid = 1'b0;
        tick();
        check("sw_data2", rf_wdata, 32'h89);
        check("sw_pend_clr", pending, 32'd0);

        // reset mid-operation
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h30;
        for (int i = 0; i < 3; i++) begin
            mem_valid  = 1'b1;
            mem_rd     = 5'(20 + i);
            mem_data   = 32'hC0 + 32'(i);
            issue_mark = 1'b1;
            issue_rd   = 5'(20 + i);
            tick();
        end
        check("mr_pend", pending, 32'h0070_0000);
        rst        = 1'b1;
        mem_valid  = 1'b1;
        mem_rd     = 5'd25;
        issue_mark = 1'b1;
        issue_rd   = 5'd25;
        settle();
        check("mr_alu_ready", 32'(alu_ready), 32'd1);
        check("mr_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        rst        = 1'b0;
        mem_valid  = 1'b0;
        issue_mark = 1'b0;
        alu_valid  = 1'b0;
        check("mr_pend_clr", pending, 32'd0);
        check("mr_we", 32'(rf_we), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mr_no_we%0d", i), 32'(rf_we), 32'd0);
        end
        check("mr_pend_end", pending, 32'd0);
        check("mr_mem_ready_end", 32'(mem_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
